// File: rtl/scale_session_controller_pkg.sv
// Shared types for the scale session controller: FSM states, result flag layout, field widths.
package scale_session_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_EVAL   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  localparam int W_WEIGHT = 9;
  localparam int W_HEIGHT = 8;
  localparam int W_CODE   = 3;
  localparam int W_RANGE  = 8;
  localparam int W_FLAGS  = 7;

  // res_flags bit positions, MSB first
  localparam int RF_OVER         = 6;
  localparam int RF_NORM         = 5;
  localparam int RF_UNDER        = 4;
  localparam int RF_BMD_NORMAL   = 3;
  localparam int RF_BMD_ABNORMAL = 2;
  localparam int RF_TYPE         = 1;
  localparam int RF_VALID        = 0;

  function automatic logic [W_WEIGHT-1:0] abs_diff(input logic [W_WEIGHT-1:0] a,
                                                   input logic [W_WEIGHT-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/scale_session_controller_if.sv
// Session bus: user/sample inputs, datapath drive and capture, and session status.
interface scale_session_controller_if;
  logic       start;
  logic       cancel;
  logic       ack;
  logic       sample_valid;
  logic [8:0] sample_weight;
  logic [7:0] height_in;
  logic       s_in;
  logic [2:0] code_tob_in;
  logic [2:0] bmdrange_in;

  logic [8:0] weight_o;
  logic [7:0] height_o;
  logic       s_o;
  logic [2:0] code_tob_o;
  logic [2:0] bmdrange_o;

  logic       ev_over;
  logic       ev_norm;
  logic       ev_under;
  logic [7:0] ev_range;
  logic       ev_bmd_normal;
  logic       ev_bmd_abnormal;
  logic       ev_type;

  logic [6:0] res_flags;
  logic [7:0] res_range;
  logic       busy;
  logic       done;
  logic       timeout_err;

  modport master (
    output start, cancel, ack, sample_valid, sample_weight, height_in, s_in,
           code_tob_in, bmdrange_in,
           ev_over, ev_norm, ev_under, ev_range, ev_bmd_normal, ev_bmd_abnormal, ev_type,
    input  weight_o, height_o, s_o, code_tob_o, bmdrange_o,
           res_flags, res_range, busy, done, timeout_err
  );

  modport slave (
    input  start, cancel, ack, sample_valid, sample_weight, height_in, s_in,
           code_tob_in, bmdrange_in,
           ev_over, ev_norm, ev_under, ev_range, ev_bmd_normal, ev_bmd_abnormal, ev_type,
    output weight_o, height_o, s_o, code_tob_o, bmdrange_o,
           res_flags, res_range, busy, done, timeout_err
  );
endinterface

// File: rtl/scale_session_controller_weight_stability_filter.sv
// Tracks a reference sample and counts consecutive in-tolerance samples; lock is a
// combinational pulse on the sample that brings the count to STABLE_CNT.
module scale_session_controller_weight_stability_filter
  import scale_session_controller_pkg::*;
#(
  parameter int STABLE_CNT = 4,
  parameter int TOL        = 2,
  parameter int MIN_WEIGHT = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic [W_WEIGHT-1:0] sample,
  output logic                lock
);

  logic [W_WEIGHT-1:0] ref_q, ref_d;
  logic [3:0]          stab_q, stab_d;

  always_comb begin
    ref_d  = ref_q;
    stab_d = stab_q;
    if (sample < W_WEIGHT'(MIN_WEIGHT)) begin
      stab_d = 4'd0;
    end else if (stab_q == 4'd0 || abs_diff(sample, ref_q) > W_WEIGHT'(TOL)) begin
      ref_d  = sample;
      stab_d = 4'd1;
    end else begin
      stab_d = stab_q + 4'd1;
    end
  end

  assign lock = en && (stab_d == 4'(STABLE_CNT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q  <= '0;
      stab_q <= '0;
    end else if (clr) begin
      ref_q  <= '0;
      stab_q <= '0;
    end else if (en) begin
      ref_q  <= ref_d;
      stab_q <= stab_d;
    end
  end

endmodule

// File: rtl/scale_session_controller.sv
// Session FSM: settle on a stable weight, latch datapath inputs, wait EVAL_CYCLES,
// capture classifier results and hold them behind done/timeout_err until ack.
module scale_session_controller
  import scale_session_controller_pkg::*;
#(
  parameter int STABLE_CNT      = 4,
  parameter int TOL             = 2,
  parameter int MIN_WEIGHT      = 20,
  parameter int TIMEOUT_SAMPLES = 32,
  parameter int EVAL_CYCLES     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  scale_session_controller_if.slave bus
);

  state_t     state;
  logic [7:0] to_cnt;
  logic [7:0] to_next;
  logic [3:0] ev_cnt;
  logic       filt_clr;
  logic       filt_en;
  logic       lock;

  assign filt_clr = (state == ST_IDLE) && bus.start;
  assign filt_en  = (state == ST_SETTLE) && bus.sample_valid;
  assign to_next  = (to_cnt == 8'hFF) ? to_cnt : to_cnt + 8'd1;

  scale_session_controller_weight_stability_filter #(
    .STABLE_CNT (STABLE_CNT),
    .TOL        (TOL),
    .MIN_WEIGHT (MIN_WEIGHT)
  ) u_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (filt_clr),
    .en     (filt_en),
    .sample (bus.sample_weight),
    .lock   (lock)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      to_cnt          <= '0;
      ev_cnt          <= '0;
      bus.weight_o    <= '0;
      bus.height_o    <= '0;
      bus.s_o         <= 1'b0;
      bus.code_tob_o  <= '0;
      bus.bmdrange_o  <= '0;
      bus.res_flags   <= '0;
      bus.res_range   <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state    <= ST_SETTLE;
            to_cnt   <= '0;
            bus.busy <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (bus.cancel) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end else if (bus.sample_valid) begin
            to_cnt <= to_next;
            // a lock on the timeout sample still counts as a lock
            if (lock) begin
              state          <= ST_EVAL;
              ev_cnt         <= '0;
              bus.weight_o   <= bus.sample_weight;
              bus.height_o   <= bus.height_in;
              bus.s_o        <= bus.s_in;
              bus.code_tob_o <= bus.code_tob_in;
              bus.bmdrange_o <= bus.bmdrange_in;
            end else if (to_next >= 8'(TIMEOUT_SAMPLES)) begin
              state           <= ST_ERR;
              bus.busy        <= 1'b0;
              bus.timeout_err <= 1'b1;
            end
          end
        end
        ST_EVAL: begin
          if (bus.cancel) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end else if (ev_cnt == 4'(EVAL_CYCLES - 1)) begin
            state         <= ST_HOLD;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.res_range <= bus.ev_range;
            bus.res_flags <= {bus.ev_over, bus.ev_norm, bus.ev_under,
                              bus.ev_bmd_normal, bus.ev_bmd_abnormal, bus.ev_type, 1'b1};
          end else begin
            ev_cnt <= ev_cnt + 4'd1;
          end
        end
        ST_HOLD: begin
          if (bus.ack) begin
            state    <= ST_IDLE;
            bus.done <= 1'b0;
          end
        end
        ST_ERR: begin
          if (bus.ack) begin
            state           <= ST_IDLE;
            bus.timeout_err <= 1'b0;
          end
        end
        default: begin
          state           <= ST_IDLE;
          bus.busy        <= 1'b0;
          bus.done        <= 1'b0;
          bus.timeout_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scale_session_controller.sv
// Scoreboarded bench: sessions are issued with random gaps/profiles, expected outcomes are
// queued at the deciding sample, and a negedge monitor checks each done/timeout_err.
module tb_scale_session_controller;

  localparam int STABLE_CNT      = 4;
  localparam int TOL             = 2;
  localparam int MIN_WEIGHT      = 20;
  localparam int TIMEOUT_SAMPLES = 32;
  localparam int EVAL_CYCLES     = 2;

  typedef struct {
    logic       is_err;
    logic [8:0] w;
    logic [7:0] h;
    logic       s;
    logic [2:0] c;
    logic [2:0] b;
    logic [6:0] flags;
    logic [7:0] rng;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t last;
  exp_t mon_e;
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;

  scale_session_controller_if bus();

  scale_session_controller #(
    .STABLE_CNT      (STABLE_CNT),
    .TOL             (TOL),
    .MIN_WEIGHT      (MIN_WEIGHT),
    .TIMEOUT_SAMPLES (TIMEOUT_SAMPLES),
    .EVAL_CYCLES     (EVAL_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the evaluation datapath: a fixed function of the latched inputs.
  function automatic logic [13:0] dp(input logic [8:0] w, input logic [7:0] h, input logic s,
                                     input logic [2:0] c, input logic [2:0] b);
    logic [5:0] f;
    f = {w[0], w[1] ^ h[1], h[0], s, c[0], b[0]};
    return {f, w[7:0] ^ h};
  endfunction

  assign {bus.ev_over, bus.ev_norm, bus.ev_under, bus.ev_bmd_normal, bus.ev_bmd_abnormal,
          bus.ev_type, bus.ev_range} =
         dp(bus.weight_o, bus.height_o, bus.s_o, bus.code_tob_o, bus.bmdrange_o);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Reference: index of the locking sample or of the timeout sample (-1 if neither).
  function automatic void model(input int smp[$], output int lk, output int tmo);
    int r, st, to;
    r = 0; st = 0; to = 0; lk = -1; tmo = -1;
    for (int i = 0; i < smp.size(); i++) begin
      to = (to < 255) ? to + 1 : 255;
      if (smp[i] < MIN_WEIGHT) st = 0;
      else if (st == 0) begin r = smp[i]; st = 1; end
      else if ((smp[i] > r ? smp[i] - r : r - smp[i]) <= TOL) st = st + 1;
      else begin r = smp[i]; st = 1; end
      if (st == STABLE_CNT) begin lk = i; return; end
      if (to >= TIMEOUT_SAMPLES) begin tmo = i; return; end
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && ((bus.done && !prev_done) || (bus.timeout_err && !prev_err))) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {62'd0, bus.done, bus.timeout_err}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("kind_err", 64'(bus.timeout_err), 64'(mon_e.is_err));
        chk("kind_done", 64'(bus.done), 64'(!mon_e.is_err));
        chk("latency", 64'(cyc), 64'(mon_e.cyc));
        chk("latched", 64'({bus.weight_o, bus.height_o, bus.s_o, bus.code_tob_o, bus.bmdrange_o}),
            64'({mon_e.w, mon_e.h, mon_e.s, mon_e.c, mon_e.b}));
        chk("results", 64'({bus.res_flags, bus.res_range}), 64'({mon_e.flags, mon_e.rng}));
      end
    end
    prev_done = bus.done;
    prev_err  = bus.timeout_err;
  end

  task automatic rnd_prof();
    bus.height_in   = 8'($urandom);
    bus.s_in        = 1'($urandom);
    bus.code_tob_in = 3'($urandom);
    bus.bmdrange_in = 3'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_session(input int smp[$], input bit cancel_lock, input bit push);
    int   lk, tmo;
    exp_t e;
    logic [13:0] d;
    model(smp, lk, tmo);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < smp.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.sample_valid  = 1'b0;
        bus.sample_weight = 9'($urandom);
        rnd_prof();
        tick();
      end
      bus.sample_valid  = 1'b1;
      bus.sample_weight = 9'(smp[i]);
      rnd_prof();
      if (i == lk) begin
        if (cancel_lock) bus.cancel = 1'b1;
        else if (push) begin
          e.is_err = 1'b0;
          e.w = 9'(smp[i]); e.h = bus.height_in; e.s = bus.s_in;
          e.c = bus.code_tob_in; e.b = bus.bmdrange_in;
          d = dp(e.w, e.h, e.s, e.c, e.b);
          e.flags = {d[13:8], 1'b1};
          e.rng = d[7:0];
          e.cyc = cyc + 1 + EVAL_CYCLES;
          sb.push_back(e);
          last = e;
        end
      end else if (i == tmo && push) begin
        e = last;
        e.is_err = 1'b1;
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
      tick();
      bus.sample_valid = 1'b0;
      bus.cancel = 1'b0;
      if (i == lk || i == tmo) break;
    end
  endtask

  task automatic wait_out();
    int n = 0;
    while (!(bus.done || bus.timeout_err) && n < 60) begin
      tick();
      n++;
    end
    chk("output_seen", 64'(bus.done | bus.timeout_err), 64'd1);
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("ack_clears", 64'({bus.busy, bus.done, bus.timeout_err}), 64'd0);
  endtask

  initial begin
    int q[$];
    int base, mode, v;
    bus.start = 0; bus.cancel = 0; bus.ack = 0; bus.sample_valid = 0; bus.sample_weight = 0;
    bus.height_in = 0; bus.s_in = 0; bus.code_tob_in = 0; bus.bmdrange_in = 0;
    last = '{default: 0};
    #12;
    chk("reset_outputs", 64'({bus.weight_o, bus.height_o, bus.s_o, bus.code_tob_o, bus.bmdrange_o,
        bus.res_flags, bus.res_range, bus.busy, bus.done, bus.timeout_err}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    run_session('{70, 71, 69, 70}, 0, 1);           wait_out(); do_ack();
    run_session('{70, 75, 75, 76, 74}, 0, 1);       wait_out(); do_ack();
    run_session('{10, 10, 80, 80, 80, 80}, 0, 1);   wait_out(); do_ack();
    q = {};
    for (int k = 0; k < 32; k++) q.push_back((k % 2 == 0) ? 50 : 60);
    run_session(q, 0, 1);                           wait_out(); do_ack();

    run_session('{90, 90, 90, 90}, 1, 0);
    chk("cancel_idle", 64'({bus.busy, bus.done, bus.timeout_err}), 64'd0);
    chk("cancel_keeps_weight", 64'(bus.weight_o), 64'(last.w));
    repeat (4) tick();
    chk("cancel_no_done", 64'(bus.done), 64'd0);

    run_session('{100, 101, 100, 99}, 0, 1);
    wait_out();
    bus.start = 1'b1; bus.ack = 1'b1;
    tick();
    bus.start = 1'b0; bus.ack = 1'b0;
    chk("hold_start_ack_idle", 64'({bus.busy, bus.done}), 64'd0);
    repeat (3) tick();
    chk("hold_start_no_restart", 64'(bus.busy), 64'd0);

    repeat (25) begin
      q = {};
      base = $urandom_range(30, 480);
      mode = $urandom_range(0, 3);
      for (int k = 0; k < 40; k++) begin
        case (mode)
          0: v = base + $urandom_range(0, 4) - 2;
          1: v = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 19) : base + $urandom_range(0, 6) - 3;
          2: v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511) : base + $urandom_range(0, 4) - 2;
          default: v = (k % 2 == 0) ? base : base + 3 + $urandom_range(0, 20);
        endcase
        q.push_back(v);
      end
      run_session(q, 0, 1);
      wait_out();
      do_ack();
    end

    run_session('{200, 200, 200, 200}, 0, 0);
    chk("eval_busy", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({bus.weight_o, bus.height_o, bus.s_o, bus.code_tob_o,
        bus.bmdrange_o, bus.res_flags, bus.res_range, bus.busy, bus.done, bus.timeout_err}), 64'd0);
    last = '{default: 0};
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) tick();
    chk("post_reset_idle", 64'({bus.busy, bus.done, bus.timeout_err}), 64'd0);

    run_session('{60, 60, 61, 60}, 0, 1);           wait_out(); do_ack();

    repeat (5) tick();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scale_session_controller.md
Name: scale_session_controller

Overview:
Sequences one smart-scale measurement session around the combinational evaluation datapath (BMI, BFP, BMD and body-type classifiers).
- Accepts a raw weight sample stream and waits for the reading to settle.
- Latches the stable weight together with the user profile, drives the evaluation inputs, and captures the classifier outputs into registers.
- Holds the results behind a done/ack handshake.

Parameters:
STABLE_CNT, 4, consecutive in-tolerance samples required for lock (2..15)
TOL, 2, max absolute difference (weight LSBs) from reference sample
MIN_WEIGHT, 20, samples below this count as empty scale
TIMEOUT_SAMPLES, 32, valid samples allowed in SETTLE before error (<=255)
EVAL_CYCLES, 2, clocks the datapath inputs are held before capture (1..15)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin session (honoured only in IDLE)
cancel  in  1  abort session (SETTLE/EVAL only)
ack  in  1  consumer acknowledges done or timeout_err
sample_valid  in  1  sample_weight valid this cycle
sample_weight  in  9  raw weight sample
height_in  in  8  user height
s_in  in  1  user sex select
code_tob_in  in  3  body-type code
bmdrange_in  in  3  bone-density range code
weight_o  out  9  latched weight to datapath
height_o  out  8  latched height to datapath
s_o  out  1  latched sex to datapath
code_tob_o  out  3  latched code to datapath
bmdrange_o  out  3  latched code to datapath
ev_over, ev_norm, ev_under  in  1 each  BMI classifier outputs
ev_range  in  8  BFP range output
ev_bmd_normal, ev_bmd_abnormal  in  1 each  BMD outputs
ev_type  in  1  body-type output
res_flags  out  7  captured {ev_over, ev_norm, ev_under, ev_bmd_normal, ev_bmd_abnormal, ev_type, 1'b1 valid}
res_range  out  8  captured ev_range
busy  out  1  state is SETTLE or EVAL
done  out  1  state is HOLD
timeout_err  out  1  state is ERR

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs, latches, counters and reference = 0.
- IDLE -> SETTLE on start; ref, stab_cnt and to_cnt cleared.
- SETTLE, per valid sample:
  - to_cnt increments, saturating.
  - sample < MIN_WEIGHT: stab_cnt=0.
  - stab_cnt==0: ref=sample, stab_cnt=1.
  - |sample-ref| <= TOL (10-bit unsigned compare, no wrap): stab_cnt++.
  - Any other sample: ref=sample, stab_cnt=1.
- Lock: the sample that makes stab_cnt==STABLE_CNT latches weight_o=that sample, and height_o/s_o/code_tob_o/bmdrange_o = current inputs. Next state EVAL.
- Timeout: to_cnt reaching TIMEOUT_SAMPLES on a non-locking sample -> ERR. Lock on the same sample as timeout wins.
- EVAL: counts EVAL_CYCLES clocks. On the last one, captures res_flags/res_range from the ev_* inputs, then -> HOLD.
- Latency: start to done = 1 + (cycles to receive the locking sample) + EVAL_CYCLES.
- HOLD: done=1 until ack. ack -> IDLE; results and latched datapath inputs persist until the next capture/lock.
- ERR: timeout_err=1 until ack. ack -> IDLE; previous results are not modified.
- cancel in SETTLE/EVAL -> IDLE next cycle, no capture, no done. cancel beats lock, timeout and EVAL completion in the same cycle. cancel is ignored in IDLE/HOLD/ERR.
- start outside IDLE is ignored. In HOLD, start with ack -> IDLE only; start must be reasserted.
- sample_valid outside SETTLE is ignored.
- ack outside HOLD/ERR is ignored.

Decomposition:
- Shared package/header: state encoding constants (IDLE, SETTLE, EVAL, HOLD, ERR) and the res_flags bit positions.
- One sub-module is natural: weight_stability_filter (ref register, tolerance compare, stab_cnt, lock pulse), cleared by the controller on SETTLE entry.
- Top level: FSM, to_cnt, EVAL counter, input/result registers.
- Bench instantiates the controller beside the existing evaluation datapath.

Test Plan:
- Parameters STABLE_CNT=4, TOL=2, MIN_WEIGHT=20, TIMEOUT_SAMPLES=32, EVAL_CYCLES=2.
- Basic lock: start; samples 70,71,69,70 -> lock on the 4th sample; weight_o=70; done 2 clocks later with res_range = ev_range; ack -> IDLE, done=0.
- Jitter reset: samples 70,75,75,76,74 -> 75 re-references, lock at 74 (stab_cnt 1..4); weight_o=74.
- Empty scale: samples 10,10,80,80,80,80 -> lock at the 6th sample; weight_o=80.
- Timeout: 32 alternating samples 50/60 -> timeout_err=1, done never set; res_* unchanged; ack -> IDLE.
- Cancel: cancel asserted in the same cycle as the locking sample -> IDLE, no done, weight_o keeps its prior value; start in HOLD together with ack -> IDLE only.
- Async reset: rst_n low mid-EVAL -> all outputs 0 immediately, without a clock edge; state IDLE after release.
